// File: rtl/ic_mem_ctrl_pkg.sv
// Shared types for the instruction-cache refill responder.
package ic_mem_ctrl_pkg;

  typedef logic [26:4]  ic_line_addr_t;
  typedef logic [1:0]   ic_xid_t;
  typedef logic [127:0] ic_line_t;

  typedef struct packed {
    ic_line_addr_t addr;
    ic_xid_t       xid;
  } ic_mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    RESP
  } ic_mc_state_e;

  localparam int unsigned IC_BEATS_PER_LINE = 4;

endpackage

// File: rtl/ic_mem_req_fifo.sv
// Request queue for ic_mem_ctrl: DEPTH-entry synchronous FIFO of {addr, xid}.
module ic_mem_req_fifo
  import ic_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [$bits(ic_mem_req_t)-1:0]  push_data,
  input  logic                            pop,
  output logic [$bits(ic_mem_req_t)-1:0]  pop_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ic_mem_req_t    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ic_mem_ctrl.sv
// Memory-side responder for I-cache refills: queues line reads, fetches four
// 32-bit SRAM beats per line and returns the assembled line with its xid.
module ic_mem_ctrl
  import ic_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [26:4]   ic_mem_addr,
  input  logic [1:0]    ic_mem_xid,
  input  logic          ic_mem_re,
  output logic          mem_ic_ready,
  output logic          mem_ic_valid,
  output logic [1:0]    mem_ic_xid,
  output logic [127:0]  mem_ic_data,
  output logic          sram_re,
  output logic [26:2]   sram_addr,
  input  logic [31:0]   sram_rdata,
  output logic          req_drop
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ic_mc_state_e   state_q, state_d;
  ic_mem_req_t    push_req, head_req;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;

  ic_line_addr_t  cur_addr_q;
  ic_xid_t        cur_xid_q;
  logic [1:0]     beat_q;
  logic [2:0]     cap_q;
  ic_line_t       line_q, line_d;
  ic_line_t       data_q;
  ic_xid_t        xid_q;
  logic           drop_q;

  logic           sh_vld  [SRAM_LAT];
  logic [1:0]     sh_beat [SRAM_LAT];
  logic           cap_hit;
  logic [1:0]     cap_beat;
  logic           load_out;

  assign push_req     = '{addr: ic_mem_addr, xid: ic_mem_xid};
  assign mem_ic_ready = !rst && (fifo_count < CW'(DEPTH));
  assign fifo_push    = ic_mem_re && !rst && !fifo_full;
  assign fifo_pop     = (state_q == IDLE) && !fifo_empty;

  ic_mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cap_hit  = sh_vld[SRAM_LAT-1];
  assign cap_beat = sh_beat[SRAM_LAT-1];

  always_comb begin
    line_d = line_q;
    if (cap_hit) begin
      line_d[{cap_beat, 5'd0} +: 32] = sram_rdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    sram_re      = 1'b0;
    sram_addr    = '0;
    mem_ic_valid = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = READ;
      READ: begin
        sram_re   = 1'b1;
        sram_addr = {cur_addr_q, beat_q};
        if (beat_q == 2'(IC_BEATS_PER_LINE - 1)) state_d = WAIT;
      end
      // Count the beat landing this cycle so RESP follows the last capture directly.
      WAIT: if ((cap_q + {2'b00, cap_hit}) == 3'(IC_BEATS_PER_LINE)) state_d = RESP;
      RESP: begin
        mem_ic_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_out = (state_q == WAIT) && (state_d == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cur_xid_q  <= '0;
      beat_q     <= '0;
      cap_q      <= '0;
      line_q     <= '0;
      data_q     <= '0;
      xid_q      <= '0;
      drop_q     <= 1'b0;
      for (int unsigned i = 0; i < SRAM_LAT; i++) begin
        sh_vld[i]  <= 1'b0;
        sh_beat[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      if (fifo_pop) begin
        cur_addr_q <= head_req.addr;
        cur_xid_q  <= head_req.xid;
        beat_q     <= '0;
        cap_q      <= '0;
      end else begin
        if (state_q == READ) beat_q <= beat_q + 2'd1;
        if (cap_hit)         cap_q  <= cap_q + 3'd1;
      end
      if (load_out) begin
        data_q <= line_d;
        xid_q  <= cur_xid_q;
      end
      if (ic_mem_re && !mem_ic_ready) drop_q <= 1'b1;
      sh_vld[0]  <= sram_re;
      sh_beat[0] <= beat_q;
      for (int unsigned i = 1; i < SRAM_LAT; i++) begin
        sh_vld[i]  <= sh_vld[i-1];
        sh_beat[i] <= sh_beat[i-1];
      end
    end
  end

  assign mem_ic_data = data_q;
  assign mem_ic_xid  = xid_q;
  assign req_drop    = drop_q;

endmodule

// File: tb/tb_ic_mem_ctrl.sv
// Directed bench for ic_mem_ctrl: a cycle table for reset and a single refill,
// then scheduled traffic for burst, overflow, push/pop at full-1 and reset mid-read.
module tb_ic_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ic_mem_re = 1'b0;
  logic [26:4]  ic_mem_addr = '0;
  logic [1:0]   ic_mem_xid = '0;

  logic         rdy1, vld1, sre1, drop1;
  logic [1:0]   xid1;
  logic [127:0] data1;
  logic [26:2]  saddr1;
  logic [31:0]  rdata1 = 32'hDEAD_BEEF;

  logic         rdy3, vld3, sre3, drop3;
  logic [1:0]   xid3;
  logic [127:0] data3;
  logic [26:2]  saddr3;
  logic [31:0]  rdata3;
  logic [31:0]  p3 [3];

  always #5 clk = ~clk;

  ic_mem_ctrl #(.DEPTH(4), .SRAM_LAT(1)) dut (
    .clk(clk), .rst(rst), .ic_mem_addr(ic_mem_addr), .ic_mem_xid(ic_mem_xid),
    .ic_mem_re(ic_mem_re), .mem_ic_ready(rdy1), .mem_ic_valid(vld1),
    .mem_ic_xid(xid1), .mem_ic_data(data1), .sram_re(sre1), .sram_addr(saddr1),
    .sram_rdata(rdata1), .req_drop(drop1)
  );

  ic_mem_ctrl #(.DEPTH(4), .SRAM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .ic_mem_addr(ic_mem_addr), .ic_mem_xid(ic_mem_xid),
    .ic_mem_re(ic_mem_re), .mem_ic_ready(rdy3), .mem_ic_valid(vld3),
    .mem_ic_xid(xid3), .mem_ic_data(data3), .sram_re(sre3), .sram_addr(saddr3),
    .sram_rdata(rdata3), .req_drop(drop3)
  );

  function automatic logic [31:0] sram_word(input logic [24:0] a);
    return {7'h55, a};
  endfunction

  function automatic logic [127:0] exp_line(input logic [22:0] la);
    logic [24:0] b;
    b = {la, 2'b00};
    return {sram_word(b + 25'd3), sram_word(b + 25'd2), sram_word(b + 25'd1), sram_word(b)};
  endfunction

  // SRAM models: garbage when no read was issued, so unqualified captures show up.
  always @(posedge clk) rdata1 <= sre1 ? sram_word(saddr1) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    p3[0] <= sre3 ? sram_word(saddr3) : 32'hDEAD_BEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata3 = p3[2];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_apply(input logic r, input logic re, input logic [22:0] a, input logic [1:0] x);
    @(posedge clk);
    #1;
    rst = r; ic_mem_re = re; ic_mem_addr = a; ic_mem_xid = x;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        re;
    logic [22:0] addr;
    logic [1:0]  xid;
    logic        rdy;
    logic        sre;
    logic [24:0] saddr;
    logic        vld;
    logic [1:0]  vxid;
    logic        v3;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic re, input logic [22:0] a,
                              input logic [1:0] x, input logic rdy, input logic sre,
                              input logic [24:0] sa, input logic v, input logic [1:0] vx,
                              input logic v3);
    vec_t t;
    t = '{rst: r, re: re, addr: a, xid: x, rdy: rdy, sre: sre, saddr: sa,
          vld: v, vxid: vx, v3: v3};
    return t;
  endfunction

  vec_t tbl [14];

  logic        s_rst [80];
  logic        s_re  [80];
  logic [22:0] s_addr[80];
  logic [1:0]  s_xid [80];
  logic        s_rchk[80];
  logic        s_rexp[80];
  int          r_cyc [$];
  logic [1:0]  r_xid [$];
  logic [127:0] r_data[$];
  logic [1:0]  e_xid [8];
  logic [22:0] e_addr[8];

  task automatic clear_sched();
    for (int i = 0; i < 80; i++) begin
      s_rst[i] = 1'b0; s_re[i] = 1'b0; s_addr[i] = '0; s_xid[i] = '0;
      s_rchk[i] = 1'b0; s_rexp[i] = 1'b0;
    end
  endtask

  task automatic sched_req(input int c, input logic [22:0] a, input logic [1:0] x, input logic rdy_exp);
    s_re[c] = 1'b1; s_addr[c] = a; s_xid[c] = x; s_rchk[c] = 1'b1; s_rexp[c] = rdy_exp;
  endtask

  task automatic run(input int ncyc);
    r_cyc.delete(); r_xid.delete(); r_data.delete();
    for (int c = 0; c < ncyc; c++) begin
      step_apply(s_rst[c], s_re[c], s_addr[c], s_xid[c]);
      if (s_rchk[c]) chk($sformatf("ready c%0d", c), 128'(rdy1), 128'(s_rexp[c]));
      if (vld1) begin
        r_cyc.push_back(c); r_xid.push_back(xid1); r_data.push_back(data1);
      end
    end
  endtask

  task automatic chk_resps(input string tag, input int n, input int first, input int gap);
    chk({tag, " resp count"}, 128'(r_cyc.size()), 128'(n));
    for (int i = 0; i < n && i < r_cyc.size(); i++) begin
      chk($sformatf("%s resp%0d cycle", tag, i), 128'(r_cyc[i]), 128'(first + gap * i));
      chk($sformatf("%s resp%0d xid", tag, i), 128'(r_xid[i]), 128'(e_xid[i]));
      chk($sformatf("%s resp%0d data", tag, i), r_data[i], exp_line(e_addr[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then one refill at addr 0x10 / xid 2 starting in row 3 (cycle 0).
    tbl[0]  = mk(1'b1, 1'b0, 23'h0,  2'd0, 1'b0, 1'b0, 25'h0,  1'b0, 2'd0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 23'h0,  2'd0, 1'b0, 1'b0, 25'h0,  1'b0, 2'd0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b0, 25'h0,  1'b0, 2'd0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 23'h10, 2'd2, 1'b1, 1'b0, 25'h0,  1'b0, 2'd0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b0, 25'h0,  1'b0, 2'd0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b1, 25'h40, 1'b0, 2'd0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b1, 25'h41, 1'b0, 2'd0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b1, 25'h42, 1'b0, 2'd0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b1, 25'h43, 1'b0, 2'd0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b0, 25'h0,  1'b0, 2'd0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b0, 25'h0,  1'b1, 2'd2, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b0, 25'h0,  1'b0, 2'd2, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b0, 25'h0,  1'b0, 2'd2, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 23'h0,  2'd0, 1'b1, 1'b0, 25'h0,  1'b0, 2'd2, 1'b0);

    for (int i = 0; i < 14; i++) begin
      step_apply(tbl[i].rst, tbl[i].re, tbl[i].addr, tbl[i].xid);
      chk($sformatf("row%0d ready", i),     128'(rdy1),   128'(tbl[i].rdy));
      chk($sformatf("row%0d sram_re", i),   128'(sre1),   128'(tbl[i].sre));
      chk($sformatf("row%0d sram_addr", i), 128'(saddr1), 128'(tbl[i].saddr));
      chk($sformatf("row%0d valid", i),     128'(vld1),   128'(tbl[i].vld));
      chk($sformatf("row%0d xid", i),       128'(xid1),   128'(tbl[i].vxid));
      chk($sformatf("row%0d lat3 sram_re", i), 128'(sre3), 128'(tbl[i].sre));
      chk($sformatf("row%0d lat3 valid", i),   128'(vld3), 128'(tbl[i].v3));
      if (i == 2) begin
        chk("reset data", data1, 128'h0);
        chk("reset drop", 128'(drop1), 128'h0);
      end
      if (tbl[i].vld) chk($sformatf("row%0d data", i), data1, exp_line(23'h10));
      if (tbl[i].v3) begin
        chk($sformatf("row%0d lat3 data", i), data3, exp_line(23'h10));
        chk($sformatf("row%0d lat3 xid", i), 128'(xid3), 128'h2);
      end
    end
    chk("data hold after resp", data1, exp_line(23'h10));

    // Burst of four back-to-back requests.
    clear_sched();
    for (int i = 0; i < 4; i++) begin
      sched_req(i, 23'h100 + 23'(i), 2'(i), 1'b1);
      e_xid[i] = 2'(i); e_addr[i] = 23'h100 + 23'(i);
    end
    run(40);
    chk_resps("burst", 4, 7, 7);

    // Six requests into a 4-deep queue while the first is in service.
    chk("drop before overflow", 128'(drop1), 128'h0);
    clear_sched();
    for (int i = 0; i < 6; i++) begin
      sched_req(i, 23'h200 + 23'(i), 2'(i % 4), (i < 5) ? 1'b1 : 1'b0);
      if (i < 5) begin
        e_xid[i] = 2'(i % 4); e_addr[i] = 23'h200 + 23'(i);
      end
    end
    run(60);
    chk_resps("overflow", 5, 7, 7);
    chk("drop after overflow", 128'(drop1), 128'h1);
    chk("lat3 drop after overflow", 128'(drop3), 128'h1);
    clear_sched();
    s_rst[0] = 1'b1;
    run(2);
    chk("drop cleared by reset", 128'(drop1), 128'h0);

    // Push in the same cycle as the IDLE pop with three entries queued.
    clear_sched();
    for (int i = 0; i < 4; i++) sched_req(i, 23'h400 + 23'(i), 2'(i), 1'b1);
    sched_req(8, 23'h404, 2'd0, 1'b1);
    sched_req(9, 23'h405, 2'd1, 1'b1);
    s_rchk[10] = 1'b1; s_rexp[10] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e_xid[i] = 2'(i % 4); e_addr[i] = 23'h400 + 23'(i);
    end
    run(60);
    chk_resps("pushpop", 6, 7, 7);
    chk("pushpop no drop", 128'(drop1), 128'h0);

    // Reset while beat 2 is being issued.
    clear_sched();
    sched_req(0, 23'h300, 2'd1, 1'b1);
    run(4);
    step_apply(1'b1, 1'b0, 23'h0, 2'd0);
    chk("midread beat2 sram_re", 128'(sre1), 128'h1);
    chk("midread beat2 addr", 128'(saddr1), 128'({23'h300, 2'b10}));
    step_apply(1'b0, 1'b0, 23'h0, 2'd0);
    chk("post-reset valid", 128'(vld1), 128'h0);
    chk("post-reset sram_re", 128'(sre1), 128'h0);
    chk("post-reset sram_addr", 128'(saddr1), 128'h0);
    chk("post-reset xid", 128'(xid1), 128'h0);
    chk("post-reset data", data1, 128'h0);
    chk("post-reset drop", 128'(drop1), 128'h0);
    chk("post-reset ready", 128'(rdy1), 128'h1);
    clear_sched();
    run(20);
    chk("flushed entry responses", 128'(r_cyc.size()), 128'h0);
    clear_sched();
    sched_req(0, 23'h3F0, 2'd3, 1'b1);
    e_xid[0] = 2'd3; e_addr[0] = 23'h3F0;
    run(12);
    chk_resps("after reset", 1, 7, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
